// File: rtl/lpc_operand_packer.sv
// Operand packer for the bit-brick multiplier: packs 2/4/8-bit element pairs into 8-bit x/y lane words
// and emits res_valid/res_last aligned with the multiplier's mac_out.
module lpc_operand_packer #(
  parameter int RES_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_last,
  output logic [7:0]       x,
  output logic [7:0]       y,
  output logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             res_valid,
  output logic             res_last,
  output logic             err_mode,
  output logic [CNT_W-1:0] words_out
);

  logic [7:0]       acc_x_q, acc_x_d;
  logic [7:0]       acc_y_q, acc_y_d;
  logic [1:0]       acc_mode_q, acc_mode_d;
  logic [1:0]       lane_cnt_q, lane_cnt_d;
  logic             acc_nonempty_q, acc_nonempty_d;

  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [1:0]       mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             err_q, err_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [RES_LAT-1:0] res_v_q, res_l_q;

  logic       out_free;
  logic       mode_legal;
  logic       flush_req;
  logic       accept;
  logic       fire;
  logic [7:0] a_lane, b_lane;
  logic       lane_full;
  logic [7:0] merged_x, merged_y;

  assign out_free   = !out_valid_q | out_ready;
  assign mode_legal = (in_mode != 2'b11);
  // Mode-11 elements never force a flush; they leave the pending word alone.
  assign flush_req  = in_valid & acc_nonempty_q & mode_legal & (in_mode != acc_mode_q);
  assign in_ready   = out_free & !flush_req & !rst;
  assign accept     = in_valid & in_ready;
  assign fire       = out_valid_q & out_ready;

  // Place the incoming element into its lane, masking bits above the element width.
  always_comb begin
    a_lane    = 8'h00;
    b_lane    = 8'h00;
    lane_full = 1'b0;
    case (in_mode)
      2'b00: begin
        a_lane    = {6'b0, in_a[1:0]} << {lane_cnt_q, 1'b0};
        b_lane    = {6'b0, in_b[1:0]} << {lane_cnt_q, 1'b0};
        lane_full = (lane_cnt_q == 2'd3);
      end
      2'b01: begin
        a_lane    = {4'b0, in_a[3:0]} << {lane_cnt_q[0], 2'b00};
        b_lane    = {4'b0, in_b[3:0]} << {lane_cnt_q[0], 2'b00};
        lane_full = (lane_cnt_q == 2'd1);
      end
      2'b10: begin
        a_lane    = in_a;
        b_lane    = in_b;
        lane_full = 1'b1;
      end
      default: begin
        a_lane    = 8'h00;
        b_lane    = 8'h00;
        lane_full = 1'b0;
      end
    endcase
  end

  assign merged_x = acc_x_q | a_lane;
  assign merged_y = acc_y_q | b_lane;

  always_comb begin
    acc_x_d        = acc_x_q;
    acc_y_d        = acc_y_q;
    acc_mode_d     = acc_mode_q;
    lane_cnt_d     = lane_cnt_q;
    acc_nonempty_d = acc_nonempty_q;
    x_d            = x_q;
    y_d            = y_q;
    mode_d         = mode_q;
    out_last_d     = out_last_q;
    out_valid_d    = out_valid_q & !fire;
    err_d          = accept & !mode_legal;
    words_d        = words_q + {{(CNT_W-1){1'b0}}, fire};

    if (flush_req && out_free) begin
      x_d            = acc_x_q;
      y_d            = acc_y_q;
      mode_d         = acc_mode_q;
      out_last_d     = 1'b0;
      out_valid_d    = 1'b1;
      acc_x_d        = 8'h00;
      acc_y_d        = 8'h00;
      lane_cnt_d     = 2'd0;
      acc_nonempty_d = 1'b0;
    end else if (accept) begin
      if (!mode_legal) begin
        if (in_last && acc_nonempty_q) begin
          x_d            = acc_x_q;
          y_d            = acc_y_q;
          mode_d         = acc_mode_q;
          out_last_d     = 1'b1;
          out_valid_d    = 1'b1;
          acc_x_d        = 8'h00;
          acc_y_d        = 8'h00;
          lane_cnt_d     = 2'd0;
          acc_nonempty_d = 1'b0;
        end
      end else if (lane_full || in_last) begin
        x_d            = merged_x;
        y_d            = merged_y;
        mode_d         = in_mode;
        out_last_d     = in_last;
        out_valid_d    = 1'b1;
        acc_x_d        = 8'h00;
        acc_y_d        = 8'h00;
        lane_cnt_d     = 2'd0;
        acc_nonempty_d = 1'b0;
      end else begin
        acc_x_d        = merged_x;
        acc_y_d        = merged_y;
        acc_mode_d     = in_mode;
        lane_cnt_d     = lane_cnt_q + 2'd1;
        acc_nonempty_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_x_q        <= 8'h00;
      acc_y_q        <= 8'h00;
      acc_mode_q     <= 2'b00;
      lane_cnt_q     <= 2'd0;
      acc_nonempty_q <= 1'b0;
      x_q            <= 8'h00;
      y_q            <= 8'h00;
      mode_q         <= 2'b00;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      err_q          <= 1'b0;
      words_q        <= '0;
    end else begin
      acc_x_q        <= acc_x_d;
      acc_y_q        <= acc_y_d;
      acc_mode_q     <= acc_mode_d;
      lane_cnt_q     <= lane_cnt_d;
      acc_nonempty_q <= acc_nonempty_d;
      x_q            <= x_d;
      y_q            <= y_d;
      mode_q         <= mode_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      err_q          <= err_d;
      words_q        <= words_d;
    end
  end

  // Result tag pipe mirrors the multiplier's input and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_v_q <= '0;
      res_l_q <= '0;
    end else begin
      for (int i = RES_LAT - 1; i > 0; i--) begin
        res_v_q[i] <= res_v_q[i-1];
        res_l_q[i] <= res_l_q[i-1];
      end
      res_v_q[0] <= fire;
      res_l_q[0] <= fire & out_last_q;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign mode      = mode_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign res_valid = res_v_q[RES_LAT-1];
  assign res_last  = res_l_q[RES_LAT-1];
  assign err_mode  = err_q;
  assign words_out = words_q;

endmodule

// File: tb/tb_lpc_operand_packer.sv
// Bench for lpc_operand_packer: directed scenarios with fixed expectations, then a randomized run
// against an element-list reference model.
module tb_lpc_operand_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic [1:0]  in_mode;
  logic        in_last;
  logic [7:0]  x, y;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        res_valid;
  logic        res_last;
  logic        err_mode;
  logic [15:0] words_out;

  int total = 0;
  int bad   = 0;

  lpc_operand_packer #(.RES_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_last(in_last),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .res_valid(res_valid), .res_last(res_last),
    .err_mode(err_mode), .words_out(words_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_mode = 2'b00; in_last = 1'b0;
  endtask

  task automatic drive(input logic [1:0] md, input logic [7:0] a, input logic [7:0] b, input logic lst);
    in_valid = 1'b1; in_mode = md; in_a = a; in_b = b; in_last = lst;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); out_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); out_ready = 1'b1;
    cyc(); cyc();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (x !== 8'h00 || y !== 8'h00 || mode !== 2'b00) begin bad++; $display("FAIL rst_xym got=%h/%h/%0d want=00/00/0", x, y, mode); end
    total++; if (res_valid !== 1'b0 || res_last !== 1'b0 || err_mode !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b%0b%0b%0b want=0000", res_valid, res_last, err_mode, out_last); end
    total++; if (words_out !== 16'd0) begin bad++; $display("FAIL rst_words got=%0d want=0", words_out); end
    rst = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%0b want=1", in_ready); end
    $display("info: test_reset done");
  endtask

  task automatic test_mode01();
    drive(2'b01, 8'h03, 8'h05, 1'b0); cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL m01_early_valid got=%0b want=0", out_valid); end
    drive(2'b01, 8'h0A, 8'h02, 1'b0); cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL m01_valid got=%0b want=1", out_valid); end
    total++; if (x !== 8'hA3 || y !== 8'h25 || mode !== 2'b01 || out_last !== 1'b0) begin bad++; $display("FAIL m01_word got=%h/%h/%0d/%0b want=A3/25/1/0", x, y, mode, out_last); end
    idle(); cyc();
    total++; if (out_valid !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL m01_after_fire got=%0b/%0b want=0/0", out_valid, res_valid); end
    total++; if (x !== 8'hA3 || words_out !== 16'd1) begin bad++; $display("FAIL m01_hold got=%h/%0d want=A3/1", x, words_out); end
    cyc();
    total++; if (res_valid !== 1'b1 || res_last !== 1'b0) begin bad++; $display("FAIL m01_res got=%0b/%0b want=1/0", res_valid, res_last); end
    cyc();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL m01_res_pulse got=%0b want=0", res_valid); end
    $display("info: test_mode01 x=%h y=%h", x, y);
  endtask

  task automatic test_mode00_full();
    logic [15:0] w0;
    w0 = words_out;
    drive(2'b00, 8'h01, 8'h03, 1'b0); cyc();
    drive(2'b00, 8'h02, 8'h03, 1'b0); cyc();
    drive(2'b00, 8'hFF, 8'hFF, 1'b0); cyc();
    drive(2'b00, 8'h00, 8'h03, 1'b0); cyc();
    total++; if (out_valid !== 1'b1 || x !== 8'h39 || y !== 8'hFF || out_last !== 1'b0) begin bad++; $display("FAIL m00_word got=%0b/%h/%h/%0b want=1/39/FF/0", out_valid, x, y, out_last); end
    idle(); cyc();
    total++; if (words_out !== w0 + 16'd1) begin bad++; $display("FAIL m00_words got=%0d want=%0d", words_out, w0 + 16'd1); end
    cyc(); cyc();
    $display("info: test_mode00_full x=%h", x);
  endtask

  task automatic test_last();
    drive(2'b00, 8'h01, 8'h01, 1'b0); cyc();
    drive(2'b00, 8'h02, 8'h01, 1'b1); cyc();
    total++; if (out_valid !== 1'b1 || x !== 8'h09 || y !== 8'h05 || out_last !== 1'b1) begin bad++; $display("FAIL last_word got=%0b/%h/%h/%0b want=1/09/05/1", out_valid, x, y, out_last); end
    idle(); cyc();
    total++; if (res_last !== 1'b0) begin bad++; $display("FAIL last_res_early got=%0b want=0", res_last); end
    cyc();
    total++; if (res_valid !== 1'b1 || res_last !== 1'b1) begin bad++; $display("FAIL last_res got=%0b/%0b want=1/1", res_valid, res_last); end
    cyc();
    $display("info: test_last x=%h", x);
  endtask

  task automatic test_flush();
    drive(2'b00, 8'h02, 8'h01, 1'b0); cyc();
    drive(2'b10, 8'hC8, 8'h03, 1'b0); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b want=0", in_ready); end
    cyc();
    total++; if (out_valid !== 1'b1 || x !== 8'h02 || y !== 8'h01 || mode !== 2'b00 || out_last !== 1'b0) begin bad++; $display("FAIL flush_word got=%0b/%h/%h/%0d/%0b want=1/02/01/0/0", out_valid, x, y, mode, out_last); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_again got=%0b want=1", in_ready); end
    cyc();
    total++; if (out_valid !== 1'b1 || x !== 8'hC8 || y !== 8'h03 || mode !== 2'b10) begin bad++; $display("FAIL flush_next got=%0b/%h/%h/%0d want=1/C8/03/2", out_valid, x, y, mode); end
    idle(); cyc(); cyc(); cyc();
    $display("info: test_flush x=%h mode=%0d", x, mode);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w0;
    out_ready = 1'b0;
    drive(2'b10, 8'h11, 8'h01, 1'b0); cyc();
    total++; if (out_valid !== 1'b1 || x !== 8'h11) begin bad++; $display("FAIL bp_load got=%0b/%h want=1/11", out_valid, x); end
    drive(2'b10, 8'h22, 8'h02, 1'b0); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b want=0", in_ready); end
    cyc();
    total++; if (out_valid !== 1'b1 || x !== 8'h11 || y !== 8'h01) begin bad++; $display("FAIL bp_stable got=%0b/%h/%h want=1/11/01", out_valid, x, y); end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", in_ready); end
    w0 = words_out;
    cyc();
    total++; if (out_valid !== 1'b1 || x !== 8'h22 || words_out !== w0 + 16'd1) begin bad++; $display("FAIL bp_reload got=%0b/%h/%0d want=1/22/%0d", out_valid, x, words_out, w0 + 16'd1); end
    idle(); cyc(); cyc(); cyc();
    $display("info: test_back_to_back x=%h", x);
  endtask

  task automatic test_err_rst();
    drive(2'b11, 8'h05, 8'h05, 1'b0); cyc();
    total++; if (err_mode !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL err_pulse got=%0b/%0b want=1/0", err_mode, out_valid); end
    idle(); cyc();
    total++; if (err_mode !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b want=0", err_mode); end
    drive(2'b00, 8'h01, 8'h01, 1'b0); cyc();
    idle(); rst = 1'b1; cyc();
    total++; if (out_valid !== 1'b0 || x !== 8'h00 || words_out !== 16'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL midrst got=%0b/%h/%0d/%0b want=0/00/0/0", out_valid, x, words_out, in_ready); end
    rst = 1'b0;
    drive(2'b00, 8'h03, 8'h02, 1'b1); cyc();
    total++; if (out_valid !== 1'b1 || x !== 8'h03 || y !== 8'h02 || out_last !== 1'b1) begin bad++; $display("FAIL midrst_lane0 got=%0b/%h/%h/%0b want=1/03/02/1", out_valid, x, y, out_last); end
    idle(); cyc(); cyc(); cyc();
    $display("info: test_err_rst x=%h", x);
  endtask

  // Reference model: list of pending elements plus a single output slot.
  int          pa[4], pb[4];
  int          pn;
  int          pmode;
  bit          m_ov, m_last, m_err;
  int          m_x, m_y, m_mode;
  logic [15:0] m_words;
  bit          h_f[$], h_l[$];

  function automatic int width_of(int md);
    return (md == 0) ? 2 : (md == 1) ? 4 : 8;
  endfunction

  function automatic int lanes_of(int md);
    return (md == 0) ? 4 : (md == 1) ? 2 : 1;
  endfunction

  function automatic int pack_list(bit use_b);
    int w, v;
    w = width_of(pmode);
    v = 0;
    for (int k = 0; k < pn; k++)
      v += ((use_b ? pb[k] : pa[k]) % (1 << w)) * (1 << (w * k));
    return v;
  endfunction

  task automatic test_random();
    bit iv, il, ord, free, flush, rdy, acc, fire, pre_last, load, nl;
    int a, b, md, nx, ny, nm;
    do_reset();
    pn = 0; pmode = 0; m_ov = 0; m_last = 0; m_err = 0; m_x = 0; m_y = 0; m_mode = 0; m_words = 0;
    h_f.delete(); h_l.delete();
    h_f.push_back(1'b0); h_f.push_back(1'b0); h_l.push_back(1'b0); h_l.push_back(1'b0);
    for (int n = 0; n < 3000; n++) begin
      iv  = ($urandom % 4) != 0;
      a   = $urandom % 256;
      b   = $urandom % 256;
      md  = (($urandom % 16) == 0) ? 3 : int'($urandom % 3);
      il  = ($urandom % 8) == 0;
      ord = ($urandom % 4) != 0;
      in_valid = iv; in_a = a[7:0]; in_b = b[7:0]; in_mode = md[1:0]; in_last = il; out_ready = ord;
      #1;
      free  = !m_ov || ord;
      flush = iv && pn > 0 && md != 3 && md != pmode;
      rdy   = free && !flush;
      acc   = iv && rdy;
      total++; if (in_ready !== rdy) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%0b want=%0b", n, in_ready, rdy); end
      @(posedge clk); #1;
      fire = m_ov && ord; pre_last = m_last;
      load = 0; nx = 0; ny = 0; nm = 0; nl = 0;
      m_err = acc && md == 3;
      if (flush && free) begin
        nx = pack_list(0); ny = pack_list(1); nm = pmode; nl = 0; load = 1; pn = 0;
      end else if (acc) begin
        if (md == 3) begin
          if (il && pn > 0) begin
            nx = pack_list(0); ny = pack_list(1); nm = pmode; nl = 1; load = 1; pn = 0;
          end
        end else begin
          pa[pn] = a; pb[pn] = b; pn++; pmode = md;
          if (pn == lanes_of(md) || il) begin
            nx = pack_list(0); ny = pack_list(1); nm = md; nl = il; load = 1; pn = 0;
          end
        end
      end
      if (load) begin
        m_ov = 1; m_x = nx; m_y = ny; m_mode = nm; m_last = nl;
      end else if (fire) begin
        m_ov = 0;
      end
      m_words += {15'd0, fire};
      h_f.push_back(fire); h_l.push_back(fire && pre_last);
      if (h_f.size() > 8) begin void'(h_f.pop_front()); void'(h_l.pop_front()); end
      total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rnd_out_valid n=%0d got=%0b want=%0b", n, out_valid, m_ov); end
      total++; if (x !== m_x[7:0] || y !== m_y[7:0] || mode !== m_mode[1:0]) begin bad++; $display("FAIL rnd_xym n=%0d got=%h/%h/%0d want=%h/%h/%0d", n, x, y, mode, m_x[7:0], m_y[7:0], m_mode); end
      if (m_ov) begin
        total++; if (out_last !== m_last) begin bad++; $display("FAIL rnd_out_last n=%0d got=%0b want=%0b", n, out_last, m_last); end
      end
      total++; if (err_mode !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%0b want=%0b", n, err_mode, m_err); end
      total++; if (res_valid !== h_f[h_f.size()-2] || res_last !== h_l[h_l.size()-2]) begin bad++; $display("FAIL rnd_res n=%0d got=%0b/%0b want=%0b/%0b", n, res_valid, res_last, h_f[h_f.size()-2], h_l[h_l.size()-2]); end
      total++; if (words_out !== m_words) begin bad++; $display("FAIL rnd_words n=%0d got=%0d want=%0d", n, words_out, m_words); end
    end
    idle(); out_ready = 1'b1;
    $display("info: test_random words=%0d", words_out);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; idle();
    test_reset();
    test_mode01();
    test_mode00_full();
    test_last();
    test_flush();
    test_back_to_back();
    test_err_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
